// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath
//   Single-bus processor datapath. Holds a 16-entry register file, the PC, IR,
//   MAR, MDR, Y, HI, LO, InPort and OutPort registers, a 64-bit Z result
//   register, a CON flag, a 32-bit ALU and a 512x32 word memory.
//   Each cycle exactly one source drives the shared bus, chosen by a fixed
//   priority. Any combination of load strobes captures that bus value at the
//   rising edge.
//
//   Memory starts as all zeros.
//
// Ports
//   clk, clr               clock, synchronous active-high clear
//   read, write            MDR loads from memory / memory stores MDR
//   PCout .. HIout         bus-drive selects
//   MARIn .. CONIn         register-load strobes (IncPC also selects B+1)
//   Gra, Grb, Grc          register-index select from IR fields
//   RIn, Rout, BAout       register file load / drive / base-address drive
//   add .. orSignal        ALU operation selects
//   InPortData             external input, captured by InIn
//   BusOut                 current bus value
//   OutPortData, CONout    OutPort register and CON flag
// -----------------------------------------------------------------------------
module datapath (
    input  logic        clk,
    input  logic        clr,
    input  logic        read,
    input  logic        write,
    input  logic        PCout,
    input  logic        Zlowout,
    input  logic        Zhighout,
    input  logic        MDRout,
    input  logic        Cout,
    input  logic        IN_Portout,
    input  logic        LOout,
    input  logic        HIout,
    input  logic        MARIn,
    input  logic        PCIn,
    input  logic        MDRIn,
    input  logic        IRIn,
    input  logic        YIn,
    input  logic        IncPC,
    input  logic        HiIn,
    input  logic        LoIn,
    input  logic        CIn,
    input  logic        InIn,
    input  logic        OutIn,
    input  logic        ZIn,
    input  logic        CONIn,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        RIn,
    input  logic        Rout,
    input  logic        BAout,
    input  logic        add,
    input  logic        subtract,
    input  logic        multiply,
    input  logic        divide,
    input  logic        andSignal,
    input  logic        orSignal,
    input  logic [31:0] InPortData,
    output logic [31:0] BusOut,
    output logic [31:0] OutPortData,
    output logic        CONout
);

    logic [31:0] r_gpr [0:15];
    logic [31:0] r_pc, r_ir, r_mar, r_mdr, r_y, r_hi, r_lo, r_inport, r_outport;
    logic [63:0] r_z;
    logic        r_con;
    logic [31:0] mem [0:511];

    logic [3:0]  w_sel_idx;
    logic [31:0] w_bus;
    logic [31:0] w_c_ext;
    logic [63:0] w_alu;
    logic [63:0] w_prod;
    logic        w_con_next;
    logic [8:0]  w_addr;

    // C has no register of its own here: the constant comes straight from IR,
    // so CIn has nothing to load.
    logic [36:0] w_unused_bits;
    assign w_unused_bits = {CIn, r_ir[31:27], r_mar[31:9]};

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    end

    assign w_addr  = r_mar[8:0];
    assign w_c_ext = {{13{r_ir[18]}}, r_ir[18:0]};

    // Gra beats Grb beats Grc when more than one is asserted.
    always_comb begin
        w_sel_idx = 4'd0;
        if (Gra)      w_sel_idx = r_ir[26:23];
        else if (Grb) w_sel_idx = r_ir[22:19];
        else if (Grc) w_sel_idx = r_ir[18:15];
    end

    always_comb begin
        w_bus = 32'd0;
        if (MDRout)          w_bus = r_mdr;
        else if (PCout)      w_bus = r_pc;
        else if (Zlowout)    w_bus = r_z[31:0];
        else if (Zhighout)   w_bus = r_z[63:32];
        else if (HIout)      w_bus = r_hi;
        else if (LOout)      w_bus = r_lo;
        else if (IN_Portout) w_bus = r_inport;
        else if (Cout)       w_bus = w_c_ext;
        // BAout reads R0 as zero so it can serve as a base address of 0.
        else if (BAout)      w_bus = (w_sel_idx == 4'd0) ? 32'd0 : r_gpr[w_sel_idx];
        else if (Rout)       w_bus = r_gpr[w_sel_idx];
    end

    assign w_prod = $signed({{32{r_y[31]}}, r_y}) * $signed({{32{w_bus[31]}}, w_bus});

    // A = Y, B = bus. 32-bit results land zero-extended in Z.
    always_comb begin
        w_alu = {32'd0, w_bus};
        if (IncPC)          w_alu = {32'd0, w_bus + 32'd1};
        else if (add)       w_alu = {32'd0, r_y + w_bus};
        else if (subtract)  w_alu = {32'd0, r_y - w_bus};
        else if (multiply)  w_alu = w_prod;
        else if (divide) begin
            if (w_bus == 32'd0) w_alu = 64'd0;
            else                w_alu = {32'($signed(r_y) % $signed(w_bus)),
                                         32'($signed(r_y) / $signed(w_bus))};
        end
        else if (andSignal) w_alu = {32'd0, r_y & w_bus};
        else if (orSignal)  w_alu = {32'd0, r_y | w_bus};
    end

    always_comb begin
        w_con_next = 1'b0;
        case (r_ir[20:19])
            2'b00: w_con_next = (w_bus == 32'd0);
            2'b01: w_con_next = (w_bus != 32'd0);
            2'b10: w_con_next = ~w_bus[31];
            2'b11: w_con_next = w_bus[31];
            default: w_con_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) r_gpr[i] <= 32'd0;
            r_pc      <= 32'd0;
            r_ir      <= 32'd0;
            r_mar     <= 32'd0;
            r_mdr     <= 32'd0;
            r_y       <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_inport  <= 32'd0;
            r_outport <= 32'd0;
            r_z       <= 64'd0;
            r_con     <= 1'b0;
        end else begin
            if (RIn)   r_gpr[w_sel_idx] <= w_bus;
            if (PCIn)  r_pc      <= w_bus;
            if (IRIn)  r_ir      <= w_bus;
            if (MARIn) r_mar     <= w_bus;
            if (MDRIn) r_mdr     <= read ? mem[w_addr] : w_bus;
            if (YIn)   r_y       <= w_bus;
            if (HiIn)  r_hi      <= w_bus;
            if (LoIn)  r_lo      <= w_bus;
            if (InIn)  r_inport  <= InPortData;
            if (OutIn) r_outport <= w_bus;
            // IncPC loads Z on its own so PC+1 is ready the next cycle.
            if (ZIn || IncPC) r_z <= w_alu;
            if (CONIn) r_con     <= w_con_next;
        end
    end

    // Memory is deliberately outside the clear domain.
    always_ff @(posedge clk) begin
        if (write) mem[w_addr] <= r_mdr;
    end

    assign BusOut      = w_bus;
    assign OutPortData = r_outport;
    assign CONout      = r_con;

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        read = 0, write = 0;
    logic        PCout = 0, Zlowout = 0, Zhighout = 0, MDRout = 0, Cout = 0;
    logic        IN_Portout = 0, LOout = 0, HIout = 0;
    logic        MARIn = 0, PCIn = 0, MDRIn = 0, IRIn = 0, YIn = 0, IncPC = 0;
    logic        HiIn = 0, LoIn = 0, CIn = 0, InIn = 0, OutIn = 0, ZIn = 0, CONIn = 0;
    logic        Gra = 0, Grb = 0, Grc = 0, RIn = 0, Rout = 0, BAout = 0;
    logic        add = 0, subtract = 0, multiply = 0, divide = 0;
    logic        andSignal = 0, orSignal = 0;
    logic [31:0] InPortData = 32'd0;
    logic [31:0] BusOut, OutPortData;
    logic        CONout;

    datapath dut (
        .clk(clk), .clr(clr), .read(read), .write(write),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .Cout(Cout), .IN_Portout(IN_Portout), .LOout(LOout), .HIout(HIout),
        .MARIn(MARIn), .PCIn(PCIn), .MDRIn(MDRIn), .IRIn(IRIn), .YIn(YIn),
        .IncPC(IncPC), .HiIn(HiIn), .LoIn(LoIn), .CIn(CIn), .InIn(InIn),
        .OutIn(OutIn), .ZIn(ZIn), .CONIn(CONIn),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .RIn(RIn), .Rout(Rout), .BAout(BAout),
        .add(add), .subtract(subtract), .multiply(multiply), .divide(divide),
        .andSignal(andSignal), .orSignal(orSignal),
        .InPortData(InPortData), .BusOut(BusOut), .OutPortData(OutPortData),
        .CONout(CONout)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    // scoreboard: obs_sel 0 = BusOut, 1 = OutPortData, 2 = CONout
    logic [31:0] exp_q[$];
    int          sel_q[$];
    string       name_q[$];
    logic        obs_valid = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    always @(negedge clk) begin
        if (obs_valid) begin
            logic [31:0] exp_v, act_v;
            int          sel;
            string       nm;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard: observation with empty queue, got %h expected entry", BusOut);
            end else begin
                exp_v = exp_q.pop_front();
                sel   = sel_q.pop_front();
                nm    = name_q.pop_front();
                case (sel)
                    1:       act_v = OutPortData;
                    2:       act_v = {31'd0, CONout};
                    default: act_v = BusOut;
                endcase
                if (act_v === exp_v) n_pass++;
                else $display("FAIL %s: got %h expected %h", nm, act_v, exp_v);
            end
        end
    end

    // driver tasks
    task automatic clear_strobes();
        read = 0; write = 0;
        PCout = 0; Zlowout = 0; Zhighout = 0; MDRout = 0; Cout = 0;
        IN_Portout = 0; LOout = 0; HIout = 0;
        MARIn = 0; PCIn = 0; MDRIn = 0; IRIn = 0; YIn = 0; IncPC = 0;
        HiIn = 0; LoIn = 0; CIn = 0; InIn = 0; OutIn = 0; ZIn = 0; CONIn = 0;
        Gra = 0; Grb = 0; Grc = 0; RIn = 0; Rout = 0; BAout = 0;
        add = 0; subtract = 0; multiply = 0; divide = 0;
        andSignal = 0; orSignal = 0;
        obs_valid = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    // Queue an expectation that the monitor checks in the current cycle.
    task automatic expect_obs(input int sel, input logic [31:0] v, input string nm);
        exp_q.push_back(v);
        sel_q.push_back(sel);
        name_q.push_back(nm);
        obs_valid = 1;
    endtask

    // Latch v into InPort, then leave IN_Portout set for the caller's cycle.
    task automatic drive_in(input logic [31:0] v);
        InPortData = v;
        InIn = 1;
        tick();
        IN_Portout = 1;
    endtask

    task automatic check_reg(input logic [31:0] v, input string nm);
        expect_obs(0, v, nm);
        tick();
    endtask

    task automatic load_ir(input logic [31:0] v);
        drive_in(v); IRIn = 1; tick();
    endtask

    logic [31:0] alu_b, alu_exp;

    initial begin
        // reset, with load strobes held to show clr overrides them
        clr = 1; InPortData = 32'hDEAD_BEEF; InIn = 1; ZIn = 1; PCIn = 1; IncPC = 1;
        tick();
        clr = 1; InIn = 1; ZIn = 1; PCIn = 1; IncPC = 1;
        tick();
        clr = 0;

        PCout = 1;      check_reg(32'd0, "rst_pc");
        Cout = 1;       check_reg(32'd0, "rst_ir");
        Zlowout = 1;    check_reg(32'd0, "rst_zlow");
        Zhighout = 1;   check_reg(32'd0, "rst_zhigh");
        IN_Portout = 1; check_reg(32'd0, "rst_inport");
        check_reg(32'd0, "rst_bus_idle");
        expect_obs(1, 32'd0, "rst_outport"); tick();
        expect_obs(2, 32'd0, "rst_con");     tick();

        // preload: R0=7 (IR=0 selects R0), mem[0], mem[0x55]
        drive_in(32'd7);           Gra = 1; RIn = 1; tick();
        drive_in(32'd0);           MARIn = 1; tick();
        drive_in(32'h0080_0055);   MDRIn = 1; tick();
        write = 1; tick();
        drive_in(32'h55);          MARIn = 1; tick();
        drive_in(32'h0000_1234);   MDRIn = 1; tick();
        write = 1; tick();

        // fetch
        PCout = 1; MARIn = 1; IncPC = 1; tick();
        Zlowout = 1; PCIn = 1; read = 1; MDRIn = 1; tick();
        MDRout = 1; IRIn = 1; expect_obs(0, 32'h0080_0055, "fetch_ir_bus"); tick();
        PCout = 1;           check_reg(32'd1, "fetch_pc");
        Cout = 1;            check_reg(32'h55, "fetch_ir_c");
        Gra = 1; Rout = 1;   check_reg(32'd0, "r1_after_reset");
        Grb = 1; Rout = 1;   check_reg(32'd7, "r0_rout");
        Grb = 1; BAout = 1;  check_reg(32'd0, "r0_baout_zero");

        // ld R1,0x55(R0)
        Grb = 1; BAout = 1; YIn = 1; tick();
        Cout = 1; add = 1; ZIn = 1; tick();
        Zlowout = 1; MARIn = 1; tick();
        read = 1; MDRIn = 1; tick();
        MDRout = 1; Gra = 1; RIn = 1; expect_obs(0, 32'h0000_1234, "ld_bus"); tick();
        Gra = 1; Rout = 1;   check_reg(32'h0000_1234, "ld_r1");

        // multiply
        drive_in(32'hFFFF_FFFF); YIn = 1; tick();
        drive_in(32'd2); multiply = 1; ZIn = 1; tick();
        Zlowout = 1;  check_reg(32'hFFFF_FFFE, "mul_zlow");
        Zhighout = 1; check_reg(32'hFFFF_FFFF, "mul_zhigh");

        // divide, then divide by zero
        drive_in(32'hFFFF_FFF9); YIn = 1; tick();
        drive_in(32'd2); divide = 1; ZIn = 1; tick();
        Zlowout = 1;  check_reg(32'hFFFF_FFFD, "div_quot");
        Zhighout = 1; check_reg(32'hFFFF_FFFF, "div_rem");
        drive_in(32'd0); divide = 1; ZIn = 1; tick();
        Zlowout = 1;  check_reg(32'd0, "div0_zlow");
        Zhighout = 1; check_reg(32'd0, "div0_zhigh");

        // 32-bit ops: Y=0x0000F0F0, B=0x00FF00FF
        drive_in(32'h0000_F0F0); YIn = 1; tick();
        alu_b = 32'h00FF_00FF;
        for (int op = 0; op < 6; op++) begin
            drive_in(alu_b);
            ZIn = 1;
            case (op)
                0: begin add = 1;                alu_exp = 32'h00FF_F1EF; end
                1: begin subtract = 1;           alu_exp = 32'hFF01_EFF1; end
                2: begin andSignal = 1;          alu_exp = 32'h0000_00F0; end
                3: begin orSignal = 1;           alu_exp = 32'h00FF_F0FF; end
                4: begin add = 1; subtract = 1;  alu_exp = 32'h00FF_F1EF; end
                default: begin                   alu_exp = 32'h00FF_00FF; end
            endcase
            tick();
            Zlowout = 1; check_reg(alu_exp, $sformatf("alu_op%0d_zlow", op));
            Zhighout = 1; check_reg(32'd0, $sformatf("alu_op%0d_zhigh", op));
        end

        // IncPC alone loads Z with B+1, even ahead of add
        drive_in(32'h41); IncPC = 1; add = 1; tick();
        Zlowout = 1; check_reg(32'h42, "incpc_zlow");

        // memory write then read back
        drive_in(32'h10);        MARIn = 1; tick();
        drive_in(32'h0000_ABCD); MDRIn = 1; tick();
        write = 1; tick();
        drive_in(32'd0);         MDRIn = 1; tick();
        read = 1; MDRIn = 1; tick();
        MDRout = 1;            check_reg(32'h0000_ABCD, "mem_wr_readback");
        MDRout = 1; PCout = 1; check_reg(32'h0000_ABCD, "bus_prio_mdr_pc");

        // simultaneous HI/LO load, HI beats LO on the bus
        drive_in(32'h1111_2222); HiIn = 1; LoIn = 1; tick();
        HIout = 1;            check_reg(32'h1111_2222, "hi_load");
        LOout = 1;            check_reg(32'h1111_2222, "lo_load");
        drive_in(32'h3333_4444); LoIn = 1; tick();
        HIout = 1; LOout = 1; check_reg(32'h1111_2222, "bus_prio_hi_lo");

        // OutPort
        drive_in(32'hCAFE_F00D); OutIn = 1; tick();
        expect_obs(1, 32'hCAFE_F00D, "outport"); tick();

        // CON conditions
        load_ir(32'h0008_0000);
        drive_in(32'd5); CONIn = 1; tick();
        expect_obs(2, 32'd1, "con_ne_5"); tick();
        drive_in(32'd0); CONIn = 1; tick();
        expect_obs(2, 32'd0, "con_ne_0"); tick();
        load_ir(32'h0018_0000);
        drive_in(32'h8000_0000); CONIn = 1; tick();
        expect_obs(2, 32'd1, "con_neg"); tick();
        load_ir(32'h0010_0000);
        drive_in(32'h8000_0000); CONIn = 1; tick();
        expect_obs(2, 32'd0, "con_pos"); tick();

        // C sign extension
        load_ir(32'h0004_0000);
        Cout = 1; check_reg(32'hFFFC_0000, "c_sign_ext");

        // select priority: Gra=R2, Grb=R3, Grc=R4
        load_ir(32'h011A_0000);
        drive_in(32'h22); Gra = 1; RIn = 1; tick();
        drive_in(32'h33); Grb = 1; RIn = 1; tick();
        drive_in(32'h44); Grc = 1; RIn = 1; tick();
        Gra = 1; Grb = 1; Grc = 1; Rout = 1; check_reg(32'h22, "sel_gra_wins");
        Grb = 1; Grc = 1; Rout = 1;          check_reg(32'h33, "sel_grb_wins");
        Grc = 1; Rout = 1;                   check_reg(32'h44, "sel_grc");

        // reset again: registers clear, memory survives
        clr = 1; tick(); clr = 0;
        Gra = 1; Rout = 1; check_reg(32'd0, "rst2_r0");
        drive_in(32'h10); MARIn = 1; tick();
        read = 1; MDRIn = 1; tick();
        MDRout = 1; check_reg(32'h0000_ABCD, "rst2_mem_kept");

        tick();
        tick();
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
